control_fsm: RTL
================

# control_fsm

Multicycle control sequencer for the 16-bit processor. It steps every instruction through fetch, decode, execute, memory and writeback. It drives the load strobe for the instruction register, the PC, register-file and memory control lines, and the ALU and mux selects. It handshakes with memory through `mem_ready`, and it latches the opcode (instr[3:0]) on the same edge that the instruction register captures rs1/rs2/rd.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_op` input 4: instruction-memory data bits [3:0].
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `zero` input 1: ALU zero flag.
- `ir_write` output 1: instruction-register load enable.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load qualified by `zero`.
- `pc_src` output 1: 0 selects ALU result (PC+2); 1 selects the branch-target register.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `reg_write` output 1: register-file write enable.
- `mem_to_reg` output 2: writeback source. 0 = ALU, 1 = memory data, 2 = PC.
- `alu_op` output 2: 0 = add, 1 = subtract, 2 = function taken from the opcode.
- `alu_src_b` output 2: 0 = rs2 data, 1 = sign-extended immediate, 2 = constant 2, 3 = branch offset.
- `state` output 3: current state encoding.
- `halted` output 1: core stopped.
- `illegal` output 1: the stop was caused by an undefined opcode.
- `retired` output COUNT_W: count of retired instructions.

## Operation
- Opcodes:
  - 0x0–0x3: R-type (add/sub/and/or).
  - 0x4: lw. 0x5: sw. 0x6: beq. 0x7: addi. 0x8: jal. 0xF: halt.
  - 0x9–0xE: illegal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to FETCH on the next edge, with no strobes in that cycle.
- Only `state`, `opcode_q`, `halted`, `illegal` and `retired` are registers. All other outputs decode combinationally from state, `opcode_q` and `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_read`=1, `alu_src_b`=2, `alu_op`=0.
  - If `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, `opcode_q`<=`instr_op`, next state DECODE.
  - Otherwise stay in FETCH, with `ir_write` and `pc_write` at 0.
- DECODE:
  - Drives `alu_src_b`=3, `alu_op`=0; the datapath latches the branch target.
  - Opcode 0xF goes to HALT.
  - Opcodes 0x9–0xE go to HALT and set `illegal`.
  - All other opcodes go to EXEC.
- EXEC:
  - R-type: `alu_src_b`=0, `alu_op`=2, next WB.
  - lw/sw: `alu_src_b`=1, `alu_op`=0, next MEM.
  - addi: `alu_src_b`=1, `alu_op`=0, next WB.
  - beq: `alu_src_b`=0, `alu_op`=1, `pc_write_cond`=1, `pc_src`=1, next FETCH. The PC loads only if `zero`=1.
  - jal: `pc_write`=1, `pc_src`=1, `reg_write`=1, `mem_to_reg`=2, next FETCH.
- MEM:
  - lw drives `mem_read`=1; sw drives `mem_write`=1.
  - Stay in MEM until `mem_ready`=1.
  - On `mem_ready`=1, lw goes to WB and sw goes to FETCH.
  - The request is held steady for every wait cycle.
- WB: `reg_write`=1; `mem_to_reg`=1 for lw, 0 otherwise; next FETCH.
- HALT:
  - Absorbing; only `reset` leaves it.
  - `halted`=1. All strobes are 0, including `mem_read`.
- `retired` increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps from 2^COUNT_W−1 to 0 and does not count the halt instruction.
- Reset (synchronous, active-high, highest priority in any state, including mid-MEM wait):
  - On the edge: `state`<=FETCH, `opcode_q`<=0, `halted`<=0, `illegal`<=0, `retired`<=0.
  - While `reset`=1, every strobe output is gated to 0, and `mem_to_reg`, `alu_op`, `alu_src_b` and `pc_src` are 0.
  - An aborted memory access is dropped, not replayed.

## Timing
- Cycle counts with zero wait states:
  - beq: 3 cycles. jal: 3 cycles.
  - R-type: 4 cycles. addi: 4 cycles. sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle that `mem_ready`=0 in FETCH or MEM adds one cycle.
- `ir_write` is high only in the single FETCH cycle where `mem_ready`=1. The instruction register's fields are valid from DECODE onward.
- In FETCH, `mem_ready` and `ir_write` are coincident; the same rule applies in MEM.
- `pc_write` and `pc_write_cond` are never asserted in the same cycle.
- First FETCH after reset deassertion: `mem_read`=1 in the first cycle with `reset`=0.

## Test plan
- Reset, then add (0x0) with `mem_ready` tied to 1:
  - State sequence 0,1,2,4,0.
  - `reg_write`=1 only in the state-4 cycle.
  - `retired`=1.
- lw (0x4) with `mem_ready` low for 2 cycles in MEM:
  - 7 cycles total.
  - `mem_read` held for 3 MEM cycles.
  - WB asserts `mem_to_reg`=1.
- beq (0x6), once with `zero`=1 and once with `zero`=0:
  - `pc_write_cond`=1 in EXEC with `pc_src`=1 both times.
  - Back in FETCH after 3 cycles; `retired` advances by 2.
- Opcode 0xB:
  - State goes 1 to 5; `halted`=1 and `illegal`=1.
  - Holds for 20 cycles with no strobes.
  - `reset` pulse returns state=0 and `illegal`=0.
- `reset` asserted during a sw MEM wait:
  - `mem_write` drops to 0 in the reset cycle.
  - Next state=FETCH, `retired`=0.
- COUNT_W=4, 17 back-to-back jal:
  - `retired` wraps 15 to 0 and ends at 1.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with HALT.
// Only state, latched opcode, halt flags and the retire counter are registered.
module control_fsm #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         instr_op,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         state,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_JAL  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             r_state, w_next;
  logic [3:0]         r_opcode;
  logic               r_halted, r_illegal;
  logic [COUNT_W-1:0] r_retired;
  logic               w_stop, w_bad, w_retire;

  // Zero only qualifies pc_write_cond in the datapath; the sequencer never branches on it.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  assign w_stop   = (r_opcode >= 4'h9);
  assign w_bad    = w_stop && (r_opcode != OP_HALT);
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= 4'h0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && mem_ready) r_opcode <= instr_op;
      if (r_state == S_DECODE && w_stop) begin
        r_halted  <= 1'b1;
        r_illegal <= w_bad;
      end
      if (w_retire) r_retired <= r_retired + COUNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'd0;
    alu_op        = 2'd0;
    alu_src_b     = 2'd0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd2;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        w_next    = w_stop ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (r_opcode <= 4'h3) begin
          alu_op = 2'd2;
          w_next = S_WB;
        end else begin
          case (r_opcode)
            OP_LW, OP_SW: begin
              alu_src_b = 2'd1;
              w_next    = S_MEM;
            end
            OP_ADDI: begin
              alu_src_b = 2'd1;
              w_next    = S_WB;
            end
            OP_BEQ: begin
              alu_op        = 2'd1;
              pc_write_cond = 1'b1;
              pc_src        = 1'b1;
            end
            OP_JAL: begin
              pc_write   = 1'b1;
              pc_src     = 1'b1;
              reg_write  = 1'b1;
              mem_to_reg = 2'd2;
            end
            default: w_next = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        // Request stays asserted through every wait cycle.
        mem_read  = (r_opcode == OP_LW);
        mem_write = (r_opcode == OP_SW);
        if (mem_ready) w_next = (r_opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_opcode == OP_LW) ? 2'd1 : 2'd0;
        w_next     = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    // Reset overrides every control line so an in-flight access is dropped.
    if (reset) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'd0;
      alu_op        = 2'd0;
      alu_src_b     = 2'd0;
    end
  end

  assign state   = r_state;
  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule
